// File: rtl/uart_tx_if.sv
// Control/status bundle between the APB register block (master) and the UART
// transmitter (slave): frame format, start request and the serial line status.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       start_tx;
    logic       tx;
    logic       tx_done;
    logic       start_tx_re_cfg;

    modport master (
        output tx_data, data_bit_num, stop_bit_num, parity_en, parity_type, start_tx,
        input  tx, tx_done, start_tx_re_cfg
    );

    modport slave (
        input  tx_data, data_bit_num, stop_bit_num, parity_en, parity_type, start_tx,
        output tx, tx_done, start_tx_re_cfg
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, 5-8 data bits LSB first, optional
// even/odd parity, 1 or 2 stop bits, each held for CLK_DIV clock cycles.
module uart_tx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic      clk,
    input  logic      reset_n,
    uart_tx_if.slave  bus
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // last_idx is N-1; bits above it are masked out of the parity sum
    function automatic logic frame_parity(input logic [7:0] data,
                                          input logic [2:0] last_idx,
                                          input logic       odd);
        logic [7:0] mask;
        mask = 8'hFF >> (3'd7 - last_idx);
        return odd ^ (^(data & mask));
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    last_idx_q, last_idx_d;
    logic          stop2_q, stop2_d;
    logic          par_en_q, par_en_d;
    logic          par_odd_q, par_odd_d;
    logic          tx_q, tx_d;
    logic          tx_done_q, tx_done_d;
    logic          re_cfg_q, re_cfg_d;
    logic          baud_end_s;

    assign baud_end_s = (baud_q == BAUD_LAST);

    // Next-state, counters, frame latches and registered line outputs
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_end_s ? '0 : baud_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        last_idx_d = last_idx_q;
        stop2_d    = stop2_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        tx_d       = tx_q;
        tx_done_d  = tx_done_q;
        re_cfg_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (bus.start_tx) begin
                    state_d    = S_START;
                    bit_cnt_d  = 3'd0;
                    data_d     = bus.tx_data;
                    last_idx_d = 3'd4 + {1'b0, bus.data_bit_num};
                    stop2_d    = bus.stop_bit_num;
                    par_en_d   = bus.parity_en;
                    par_odd_d  = bus.parity_type;
                    tx_d       = 1'b0;
                    tx_done_d  = 1'b0;
                    re_cfg_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = data_q[0];
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    if (bit_cnt_q == last_idx_q) begin
                        bit_cnt_d = 3'd0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = frame_parity(data_q, last_idx_q, par_odd_q);
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = data_q[bit_cnt_q + 3'd1];
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (baud_end_s) begin
                    state_d   = S_STOP;
                    bit_cnt_d = 3'd0;
                    tx_d      = 1'b1;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_end_s) begin
                    if (stop2_q && (bit_cnt_q == 3'd0)) begin
                        bit_cnt_d = 3'd1;
                    end else begin
                        state_d   = S_IDLE;
                        bit_cnt_d = 3'd0;
                        tx_done_d = 1'b1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                baud_d    = '0;
                bit_cnt_d = 3'd0;
                tx_d      = 1'b1;
                tx_done_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= 3'd0;
            data_q     <= 8'd0;
            last_idx_q <= 3'd0;
            stop2_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b1;
            re_cfg_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            last_idx_q <= last_idx_d;
            stop2_q    <= stop2_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            re_cfg_q   <= re_cfg_d;
        end
    end

    assign bus.tx              = tx_q;
    assign bus.tx_done         = tx_done_q;
    assign bus.start_tx_re_cfg = re_cfg_q;
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames from a
// bit-list reference model; a monitor checks the line cycle by cycle.
module tb_uart_tx;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    uart_tx_if bus();

    uart_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    frame_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    bit mon_busy = 1'b0;
    int last_idle_run = 0;
    int re_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Line sequence as a list of bits: start, N data LSB first, parity, stops
    function automatic frame_t model_frame(input logic [7:0] d, input logic [1:0] dbn,
                                           input logic stop2, input logic pen, input logic ptype);
        frame_t f;
        int n, ones, idx, v;
        n = 5 + int'(dbn);
        ones = 0;
        idx = 0;
        f.bits = 12'hFFF;
        f.bits[idx] = 1'b0;
        idx++;
        for (int i = 0; i < n; i++) begin
            v = (int'(d) >> i) % 2;
            f.bits[idx] = (v == 1);
            ones += v;
            idx++;
        end
        if (pen) begin
            f.bits[idx] = (((ones % 2) + int'(ptype)) % 2) == 1;
            idx++;
        end
        f.bits[idx] = 1'b1;
        idx++;
        if (stop2) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.len = idx;
        return f;
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.start_tx_re_cfg === 1'b1) re_cnt++;
    end

    // Monitor: a falling tx_done marks an accepted frame; pop and compare
    initial begin : monitor
        logic   prev, seen, re2;
        int     idle_run, low_cnt;
        bit     aborted;
        frame_t f;
        prev = 1'b1;
        idle_run = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 1'b1;
                idle_run = 0;
            end else if (prev && bus.tx_done === 1'b0) begin
                mon_busy = 1'b1;
                last_idle_run = idle_run;
                idle_run = 0;
                check("re_cfg_on_accept", bus.start_tx_re_cfg, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(exp_q.size()), 1);
                    prev = 1'b0;
                end else begin
                    f = exp_q.pop_front();
                    aborted = 1'b0;
                    low_cnt = 0;
                    re2 = 1'b0;
                    for (int b = 0; b < f.len && !aborted; b++) begin
                        seen = f.bits[b];
                        for (int c = 0; c < CLK_DIV; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (!reset_n) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (bus.tx !== f.bits[b]) seen = bus.tx;
                            if (bus.tx_done === 1'b0) low_cnt++;
                            if (b == 0 && c == 1) re2 = bus.start_tx_re_cfg;
                        end
                        if (!aborted) check($sformatf("frame_bit%0d", b), seen, f.bits[b]);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        check("re_cfg_one_cycle", re2, 0);
                        check("tx_done_low_cycles", low_cnt, f.len * CLK_DIV);
                        check("tx_done_at_end", bus.tx_done, 1);
                        check("tx_idle_at_end", bus.tx, 1);
                        idle_run = 1;
                    end
                    prev = 1'b1;
                end
                mon_busy = 1'b0;
            end else begin
                if (bus.tx_done === 1'b1) idle_run++;
                prev = bus.tx_done;
            end
        end
    end

    task automatic wait_re_cfg();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.start_tx_re_cfg === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("re_cfg_wait", ok, 1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!mon_busy && exp_q.size() == 0 && bus.tx_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_done_wait", ok, 1);
    endtask

    task automatic drive_cfg(input logic [7:0] d, input logic [1:0] dbn,
                             input logic s2, input logic pen, input logic pt);
        bus.tx_data = d;
        bus.data_bit_num = dbn;
        bus.stop_bit_num = s2;
        bus.parity_en = pen;
        bus.parity_type = pt;
        exp_q.push_back(model_frame(d, dbn, s2, pen, pt));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] dbn, input logic s2,
                              input logic pen, input logic pt, input bit scramble);
        drive_cfg(d, dbn, s2, pen, pt);
        bus.start_tx = 1'b1;
        wait_re_cfg();
        bus.start_tx = 1'b0;
        if (scramble) begin
            repeat (6) @(negedge clk);
            bus.tx_data = 8'($urandom);
            bus.data_bit_num = 2'($urandom);
            bus.stop_bit_num = 1'($urandom);
            bus.parity_en = 1'($urandom);
            bus.parity_type = 1'($urandom);
        end
        wait_done();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end

    initial begin : stimulus
        int re_before;
        bit ok;
        bus.start_tx = 1'b0;
        bus.tx_data = 8'h00;
        bus.data_bit_num = 2'b11;
        bus.stop_bit_num = 1'b0;
        bus.parity_en = 1'b0;
        bus.parity_type = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", bus.tx, 1);
        check("reset_tx_done", bus.tx_done, 1);
        check("reset_re_cfg", bus.start_tx_re_cfg, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);   // 8N1
        send_frame(8'hF3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);   // 5E2
        send_frame(8'h00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);   // 7O1
        send_frame(8'h7F, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);

        // Level held across two frames, data changed mid-first-frame
        re_before = re_cnt;
        drive_cfg(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(model_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0));
        bus.start_tx = 1'b1;
        wait_re_cfg();
        repeat (6) @(negedge clk);
        bus.tx_data = 8'h3C;
        wait_re_cfg();
        bus.start_tx = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        check("b2b_re_cfg_count", re_cnt - re_before, 2);
        check("b2b_idle_gap", last_idle_run, 1);

        // Format change during DATA of an 8N1 frame; applies to next frame
        drive_cfg(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0);
        bus.start_tx = 1'b1;
        wait_re_cfg();
        bus.start_tx = 1'b0;
        repeat (10) @(negedge clk);
        bus.data_bit_num = 2'b00;
        bus.parity_en = 1'b1;
        wait_done();
        exp_q.push_back(model_frame(bus.tx_data, bus.data_bit_num, bus.stop_bit_num,
                                    bus.parity_en, bus.parity_type));
        bus.start_tx = 1'b1;
        wait_re_cfg();
        bus.start_tx = 1'b0;
        wait_done();

        // Reset asserted during bit 3 of a frame
        drive_cfg(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0);
        bus.start_tx = 1'b1;
        wait_re_cfg();
        bus.start_tx = 1'b0;
        repeat (13) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_tx", bus.tx, 1);
        check("async_reset_tx_done", bus.tx_done, 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.tx_done !== 1'b1) ok = 1'b0;
        end
        check("post_reset_idle", ok, 1);
        check("post_reset_no_mon_frame", mon_busy, 0);
        send_frame(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            send_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                       1'($urandom), 1'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
